// File: rtl/rank_filter_pkg.sv
// Shared definitions for the 3x3 rank filter: operating modes, pipeline latency
// and position-counter widths.
package rank_filter_pkg;

  typedef enum logic [1:0] {
    MODE_MED = 2'd0,
    MODE_MIN = 2'd1,
    MODE_MAX = 2'd2,
    MODE_BYP = 2'd3
  } mode_e;

  // One window stage plus three sort stages.
  localparam int LAT   = 4;
  localparam int COL_W = 12;
  localparam int ROW_W = 12;

endpackage

// File: rtl/rank_filter_3x3_if.sv
// Video stream bundle: camera-style syncs and pixel going in, the same syncs
// delayed by the filter latency and the filtered pixel coming out.
interface rank_filter_3x3_if #(
  parameter int DATA_W = 8
);
  import rank_filter_pkg::*;

  logic              per_frame_vsync;
  logic              per_frame_href;
  logic              per_frame_clken;
  logic [DATA_W-1:0] per_img_data;
  logic [1:0]        mode;
  logic              post_frame_vsync;
  logic              post_frame_href;
  logic              post_frame_clken;
  logic [DATA_W-1:0] post_img_data;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_data, mode,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_data
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_data, mode,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_data
  );

endinterface

// File: rtl/rank_sort3.sv
// Registered three-input sorter: max/mid/min of the inputs one clock later,
// updated only while en_i is high.
module rank_sort3 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] mid_o,
  output logic [DATA_W-1:0] min_o
);

  logic [DATA_W-1:0] hi_ab_s;
  logic [DATA_W-1:0] lo_ab_s;
  logic [DATA_W-1:0] lo_hc_s;
  logic [DATA_W-1:0] max_d;
  logic [DATA_W-1:0] mid_d;
  logic [DATA_W-1:0] min_d;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] mid_q;
  logic [DATA_W-1:0] min_q;

  // lo_hc_s is the loser of the top-two contest; the median is the larger of it and lo_ab_s.
  always_comb begin
    if (a_i > b_i) begin
      hi_ab_s = a_i;
      lo_ab_s = b_i;
    end else begin
      hi_ab_s = b_i;
      lo_ab_s = a_i;
    end
    if (hi_ab_s > c_i) begin
      max_d   = hi_ab_s;
      lo_hc_s = c_i;
    end else begin
      max_d   = c_i;
      lo_hc_s = hi_ab_s;
    end
    if (lo_ab_s > lo_hc_s) begin
      mid_d = lo_ab_s;
      min_d = lo_hc_s;
    end else begin
      mid_d = lo_hc_s;
      min_d = lo_ab_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      mid_q <= '0;
      min_q <= '0;
    end else if (en_i) begin
      max_q <= max_d;
      mid_q <= mid_d;
      min_q <= min_d;
    end
  end

  assign max_o = max_q;
  assign mid_o = mid_q;
  assign min_o = min_q;

endmodule

// File: rtl/rank_filter_3x3.sv
// 3x3 rank filter (median / min / max / bypass) over a raster video stream with
// two line buffers, a sliding window and a three-stage sort network.
module rank_filter_3x3
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640
) (
  input logic              clk,
  input logic              rst_n,
  rank_filter_3x3_if.slave vid
);

  localparam int               AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_LAST = {ROW_W{1'b1}};
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic              accept_s;
  logic              href_fall_s;
  logic              vsync_rise_s;
  logic              vsync_q;
  logic              href_q;
  logic [COL_W-1:0]  col_q;
  logic [COL_W-1:0]  col_d;
  logic [ROW_W-1:0]  row_q;
  logic [ROW_W-1:0]  row_d;
  mode_e             mode_q;

  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [AW-1:0]     lb_addr_s;
  logic [DATA_W-1:0] lb0_rd_s;
  logic [DATA_W-1:0] lb1_rd_s;

  logic [DATA_W-1:0] win_q [3][3];
  logic              border_q;
  logic [1:0]        border_pipe_q;
  logic [DATA_W-1:0] cen_pipe_q [2];
  logic [LAT-1:0]    vs_pipe_q;
  logic [LAT-1:0]    hr_pipe_q;
  logic [LAT-1:0]    ck_pipe_q;

  logic [DATA_W-1:0] row_max_s [3];
  logic [DATA_W-1:0] row_mid_s [3];
  logic [DATA_W-1:0] row_min_s [3];
  logic [DATA_W-1:0] maxes_max_s, maxes_mid_s, maxes_min_s;
  logic [DATA_W-1:0] mids_max_s,  mids_mid_s,  mids_min_s;
  logic [DATA_W-1:0] mins_max_s,  mins_mid_s,  mins_min_s;
  logic [DATA_W-1:0] fin_a_s, fin_b_s, fin_c_s;
  logic [DATA_W-1:0] fin_max_s, fin_mid_s, fin_min_s;
  logic              sink_unused_s;

  assign accept_s     = vid.per_frame_href & vid.per_frame_clken;
  assign href_fall_s  = href_q & ~vid.per_frame_href;
  assign vsync_rise_s = vid.per_frame_vsync & ~vsync_q;
  assign lb_addr_s    = col_q[AW-1:0];
  assign lb0_rd_s     = lb0_mem[lb_addr_s];
  assign lb1_rd_s     = lb1_mem[lb_addr_s];

  // vsync low dominates so that a mid-line vsync pulse aborts the frame position.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (!vid.per_frame_vsync) begin
      col_d = '0;
      row_d = '0;
    end else if (href_fall_s) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? row_q : row_q + ROW_ONE;
    end else if (accept_s) begin
      col_d = (col_q == COL_LAST) ? col_q : col_q + COL_ONE;
    end else begin
      col_d = col_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= MODE_MED;
    end else begin
      vsync_q <= vid.per_frame_vsync;
      href_q  <= vid.per_frame_href;
      col_q   <= col_d;
      row_q   <= row_d;
      if (vsync_rise_s) begin
        mode_q <= mode_e'(vid.mode);
      end
    end
  end

  // Line buffers carry no reset; the border flag hides whatever they held before.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb0_mem[lb_addr_s] <= vid.per_img_data;
      lb1_mem[lb_addr_s] <= lb0_mem[lb_addr_s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
      border_q <= 1'b0;
    end else if (accept_s) begin
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= lb1_rd_s;
      win_q[1][2] <= lb0_rd_s;
      win_q[2][2] <= vid.per_img_data;
      border_q    <= (row_q < ROW_TWO) || (col_q < COL_TWO);
    end
  end

  // Sync delay lines and the centre/border side-band run every clock, gaps or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_pipe_q     <= '0;
      hr_pipe_q     <= '0;
      ck_pipe_q     <= '0;
      border_pipe_q <= '0;
      cen_pipe_q[0] <= '0;
      cen_pipe_q[1] <= '0;
    end else begin
      vs_pipe_q     <= {vs_pipe_q[LAT-2:0], vid.per_frame_vsync};
      hr_pipe_q     <= {hr_pipe_q[LAT-2:0], vid.per_frame_href};
      ck_pipe_q     <= {ck_pipe_q[LAT-2:0], accept_s};
      border_pipe_q <= {border_pipe_q[0], border_q};
      cen_pipe_q[0] <= win_q[1][1];
      cen_pipe_q[1] <= cen_pipe_q[0];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_row
    rank_sort3 #(.DATA_W(DATA_W)) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (1'b1),
      .a_i   (win_q[g][0]),
      .b_i   (win_q[g][1]),
      .c_i   (win_q[g][2]),
      .max_o (row_max_s[g]),
      .mid_o (row_mid_s[g]),
      .min_o (row_min_s[g])
    );
  end

  rank_sort3 #(.DATA_W(DATA_W)) u_maxes (
    .clk(clk), .rst_n(rst_n), .en_i(1'b1),
    .a_i(row_max_s[0]), .b_i(row_max_s[1]), .c_i(row_max_s[2]),
    .max_o(maxes_max_s), .mid_o(maxes_mid_s), .min_o(maxes_min_s)
  );

  rank_sort3 #(.DATA_W(DATA_W)) u_mids (
    .clk(clk), .rst_n(rst_n), .en_i(1'b1),
    .a_i(row_mid_s[0]), .b_i(row_mid_s[1]), .c_i(row_mid_s[2]),
    .max_o(mids_max_s), .mid_o(mids_mid_s), .min_o(mids_min_s)
  );

  rank_sort3 #(.DATA_W(DATA_W)) u_mins (
    .clk(clk), .rst_n(rst_n), .en_i(1'b1),
    .a_i(row_min_s[0]), .b_i(row_min_s[1]), .c_i(row_min_s[2]),
    .max_o(mins_max_s), .mid_o(mins_mid_s), .min_o(mins_min_s)
  );

  // Non-median results are fed in triplicate so the last sorter's mid passes them through.
  always_comb begin
    fin_a_s = cen_pipe_q[1];
    fin_b_s = cen_pipe_q[1];
    fin_c_s = cen_pipe_q[1];
    if (border_pipe_q[1]) begin
      fin_a_s = cen_pipe_q[1];
      fin_b_s = cen_pipe_q[1];
      fin_c_s = cen_pipe_q[1];
    end else begin
      case (mode_q)
        MODE_MED: begin
          fin_a_s = mins_max_s;
          fin_b_s = mids_mid_s;
          fin_c_s = maxes_min_s;
        end
        MODE_MIN: begin
          fin_a_s = mins_min_s;
          fin_b_s = mins_min_s;
          fin_c_s = mins_min_s;
        end
        MODE_MAX: begin
          fin_a_s = maxes_max_s;
          fin_b_s = maxes_max_s;
          fin_c_s = maxes_max_s;
        end
        MODE_BYP: begin
          fin_a_s = cen_pipe_q[1];
          fin_b_s = cen_pipe_q[1];
          fin_c_s = cen_pipe_q[1];
        end
        default: begin
          fin_a_s = cen_pipe_q[1];
          fin_b_s = cen_pipe_q[1];
          fin_c_s = cen_pipe_q[1];
        end
      endcase
    end
  end

  rank_sort3 #(.DATA_W(DATA_W)) u_final (
    .clk(clk), .rst_n(rst_n), .en_i(ck_pipe_q[LAT-2]),
    .a_i(fin_a_s), .b_i(fin_b_s), .c_i(fin_c_s),
    .max_o(fin_max_s), .mid_o(fin_mid_s), .min_o(fin_min_s)
  );

  assign sink_unused_s = ^{maxes_mid_s, mids_max_s, mids_min_s, mins_mid_s, fin_max_s, fin_min_s};

  assign vid.post_frame_vsync = vs_pipe_q[LAT-1];
  assign vid.post_frame_href  = hr_pipe_q[LAT-1];
  assign vid.post_frame_clken = ck_pipe_q[LAT-1];
  assign vid.post_img_data    = fin_mid_s;

endmodule

// File: tb/tb_rank_filter_3x3.sv
// Frame-level bench for rank_filter_3x3: drives whole frames and compares every
// output against a sort-of-nine window model and the input syncs four clocks earlier.
module tb_rank_filter_3x3;
  localparam int DW = 8;
  localparam int IW = 8;

  typedef struct {
    logic          vs;
    logic          hr;
    logic          ck;
    logic          chk_d;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  ent_t          hist[$];
  logic [DW-1:0] img [16][16];
  logic [1:0]    m_mode = 2'd0;
  logic          prev_vs = 1'b0;
  logic [DW-1:0] last_exp = '0;
  logic          last_known = 1'b1;
  int            vcount = 0;
  int            first_in = -1;
  int            first_out = -1;

  always #5 clk = ~clk;

  rank_filter_3x3_if #(.DATA_W(DW)) vid ();

  rank_filter_3x3 #(.DATA_W(DW), .IMG_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vid)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Rank of the 3x3 neighbourhood centred at (r-1, c-1), or the centre on the border.
  function automatic logic [DW-1:0] ref_pix(input int r, input int c, input logic [1:0] m);
    logic [DW-1:0] v[$];
    if (r < 2 || c < 2) return img[r-1][c-1];
    for (int i = r - 2; i <= r; i++)
      for (int j = c - 2; j <= c; j++)
        v.push_back(img[i][j]);
    v.sort();
    case (m)
      2'd0:    return v[4];
      2'd1:    return v[0];
      2'd2:    return v[8];
      default: return img[r-1][c-1];
    endcase
  endfunction

  task automatic step(input logic vs, input logic hr, input logic ck, input logic [DW-1:0] d,
                      input int r, input int c, input logic [1:0] md);
    ent_t e;
    ent_t o;
    vid.per_frame_vsync = vs;
    vid.per_frame_href  = hr;
    vid.per_frame_clken = ck;
    vid.per_img_data    = d;
    vid.mode            = md;
    if (vs && !prev_vs) m_mode = md;
    prev_vs = vs;
    e.vs    = vs;
    e.hr    = hr;
    e.ck    = hr & ck;
    e.chk_d = e.ck && r >= 1 && c >= 1;
    e.d     = e.chk_d ? ref_pix(r, c, m_mode) : '0;
    if (e.ck && first_in < 0) first_in = cyc;
    hist.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (vid.post_frame_clken) begin
      vcount++;
      if (first_out < 0) first_out = cyc;
    end
    if (hist.size() == 4) begin
      o = hist.pop_front();
      check_eq("post_vsync", vid.post_frame_vsync, o.vs);
      check_eq("post_href", vid.post_frame_href, o.hr);
      check_eq("post_clken", vid.post_frame_clken, o.ck);
      if (o.ck) begin
        if (o.chk_d) check_eq("pixel", vid.post_img_data, o.d);
        last_exp   = o.d;
        last_known = o.chk_d;
      end else if (last_known) begin
        check_eq("hold", vid.post_img_data, last_exp);
      end
    end
  endtask

  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_vsync", vid.post_frame_vsync, 32'd0);
    check_eq("rst_href", vid.post_frame_href, 32'd0);
    check_eq("rst_clken", vid.post_frame_clken, 32'd0);
    check_eq("rst_data", vid.post_img_data, 32'd0);
    vid.per_frame_vsync = 1'b0;
    vid.per_frame_href  = 1'b0;
    vid.per_frame_clken = 1'b0;
    hist.delete();
    m_mode     = 2'd0;
    prev_vs    = 1'b0;
    last_exp   = '0;
    last_known = 1'b1;
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input int h, input int w, input logic [1:0] md,
                           input logic [1:0] md_late, input bit gaps, input int rst_at);
    logic [1:0] mcur;
    repeat (3) step(1'b0, 1'b0, 1'b0, DW'($urandom), 0, 0, md);
    repeat (2) step(1'b1, 1'b0, 1'b0, DW'($urandom), 0, 0, md);
    for (int r = 0; r < h; r++) begin
      mcur = (r >= h / 2) ? md_late : md;
      for (int c = 0; c < w; c++) begin
        if (r * w + c == rst_at) begin
          mid_reset();
          return;
        end
        if (gaps)
          for (int g = 0; g < 6 && $urandom_range(1, 0) == 0; g++)
            step(1'b1, 1'b1, 1'b0, DW'($urandom), r, c, mcur);
        step(1'b1, 1'b1, 1'b1, img[r][c], r, c, mcur);
      end
      repeat (3) step(1'b1, 1'b0, 1'b0, DW'($urandom), 0, 0, mcur);
    end
    repeat (6) step(1'b1, 1'b0, 1'b0, DW'($urandom), 0, 0, md_late);
  endtask

  task automatic fill_const(input logic [DW-1:0] v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        img[i][j] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        img[i][j] = DW'($urandom);
  endtask

  initial begin
    rst_n               = 1'b0;
    vid.per_frame_vsync = 1'b0;
    vid.per_frame_href  = 1'b0;
    vid.per_frame_clken = 1'b0;
    vid.per_img_data    = '0;
    vid.mode            = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_vsync", vid.post_frame_vsync, 32'd0);
    check_eq("reset_href", vid.post_frame_href, 32'd0);
    check_eq("reset_clken", vid.post_frame_clken, 32'd0);
    check_eq("reset_data", vid.post_img_data, 32'd0);
    #3;
    rst_n = 1'b1;

    // Flat 8x4 frame: count of output strobes and first-output latency.
    fill_const(8'h55);
    vcount    = 0;
    first_in  = -1;
    first_out = -1;
    run_frame(4, 8, 2'd0, 2'd0, 1'b0, -1);
    check_eq("flat_clken_cnt", vcount, 32'd32);
    check_eq("flat_latency", first_out - first_in, 32'd4);

    // Single bright impulse must be removed by the median.
    fill_const(8'h10);
    img[3][3] = 8'hFF;
    run_frame(8, 8, 2'd0, 2'd0, 1'b0, -1);

    // Known 1..9 neighbourhood around (2,2) under every mode.
    for (int m = 0; m < 4; m++) begin
      fill_rand();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          img[1+i][1+j] = DW'(i * 3 + j + 1);
      run_frame(8, 8, 2'(m), 2'(m), 1'b0, -1);
    end

    // Mode changed mid-frame applies only from the next vsync rise.
    fill_rand();
    run_frame(8, 8, 2'd0, 2'd2, 1'b0, -1);
    fill_rand();
    run_frame(8, 8, 2'd2, 2'd2, 1'b0, -1);

    // Random strobe gaps with random modes.
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      run_frame(8, 8, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 1'b1, -1);
    end

    // Reset in the middle of a line, then a fresh frame with gaps.
    fill_rand();
    run_frame(8, 8, 2'd1, 2'd1, 1'b0, 20);
    fill_rand();
    run_frame(8, 8, 2'd1, 2'd1, 1'b1, -1);
    fill_rand();
    run_frame(6, 8, 2'd3, 2'd3, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rank_filter_3x3.md
RANK_FILTER_3X3 -- requirements
Module: rank_filter_3x3

Interface
REQ-001 Parameter: DATA_W, 8, pixel bit width (1..16).
REQ-002 Parameter: IMG_W, 640, active pixels per line (4..4096); line-buffer depth.
REQ-003 Port: clk  in  1  single clock; all logic rising-edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: per_frame_vsync  in  1  frame sync, high for frame duration.
REQ-006 Port: per_frame_href  in  1  line valid, high for the active part of each line.
REQ-007 Port: per_frame_clken  in  1  pixel strobe; pixel accepted only when href and clken are both high.
REQ-008 Port: per_img_data  in  DATA_W  input pixel.
REQ-009 Port: mode  in  2  0 median, 1 min, 2 max, 3 bypass.
REQ-010 Port: post_frame_vsync / post_frame_href / post_frame_clken  out  1 each  input syncs delayed by LAT.
REQ-011 Port: post_img_data  out  DATA_W  filtered pixel.

Function
REQ-012 Two line buffers of IMG_W x DATA_W hold the previous two rows; they shift only on accepted pixels.
REQ-013 A 3x3 window register shifts one column per accepted pixel; its bottom-right entry is the current input.
REQ-014 Column counter: increments per accepted pixel; clears on the href falling edge; saturates at IMG_W-1.
REQ-015 Row counter: increments on each href falling edge; clears while vsync is low; saturates at 4095.
REQ-016 Output for the input at (row r, col c) is the rank result of the window centred at (r-1, c-1).
REQ-017 Border: if r<2 or c<2, output is the window centre pixel unmodified, whatever the mode.
REQ-018 Median: three per-row sort3 stages, then max-of-mins, median-of-mids and min-of-maxes, then the median of those three; total 3 sort cycles.
REQ-019 Min mode: minimum of the row minima; max mode: maximum of the row maxima; both use the same 3-cycle tree.
REQ-020 Bypass outputs the window centre pixel, pipelined to the same latency.
REQ-021 LAT = 4 clocks (1 window + 3 sort), fixed, independent of mode and clken gaps.
REQ-022 The pipeline advances every clock; post_frame_clken is per_frame_clken AND per_frame_href, delayed by LAT.
REQ-023 post_img_data is meaningful only when post_frame_clken is high, and holds its value otherwise.
REQ-024 mode is registered on the per_frame_vsync rising edge only; mid-frame changes take effect next frame.
REQ-025 All comparisons are unsigned DATA_W-bit; there is no arithmetic widening.
REQ-026 Ties resolve deterministically: equal values are interchangeable, so the output value is unaffected.
REQ-027 A vsync low pulse mid-line aborts the frame: row and column counters clear, and the line buffers are not cleared.

Reset
REQ-028 Asserting rst_n low clears at once: post_* outputs to 0, counters to 0, window and pipeline registers to 0, registered mode to 0 (median).
REQ-029 Line-buffer contents are not reset; border rule REQ-017 masks stale data.
REQ-030 The first accepted pixel after reset release is processed normally.

Structure
REQ-031 Package rank_filter_pkg holds: the mode enum (MODE_MED, MODE_MIN, MODE_MAX, MODE_BYP), the LAT constant and the counter widths.
REQ-032 One sub-module, rank_sort3: registered 3-input sort, DATA_W-parametrised, giving max/mid/min with 1-cycle latency; instantiated 7 times.
REQ-033 Line buffers are inferred RAM or shift registers inside the top module; there is no separate module.

Verification
REQ-034 Flat frame, 8x4, all pixels 0x55, mode 0 -> every post pixel 0x55; clken count 32; first output 4 clocks after the first input.
REQ-035 Impulse: 8x8 frame of 0x10 with a single 0xFF at (3,3), mode 0 -> the output at centre (3,3) is 0x10; the 0xFF never appears at an interior output.
REQ-036 Window 1..9 around centre (2,2) -> mode 0 gives 5, mode 1 gives 1, mode 2 gives 9 (mode changed only at vsync rise), mode 3 gives the centre value.
REQ-037 Mode toggled 0->2 mid-frame -> the current frame stays median; the next frame is max.
REQ-038 Random clken gaps (50% duty) -> results match the gap-free golden model, and post syncs equal the input syncs shifted by 4 clocks.
REQ-039 rst_n pulsed low mid-line -> outputs go to 0 asynchronously; the next frame's borders (rows 0-1, cols 0-1) pass through the centre pixel.
